// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad column scanner with press/release debounce
// and a single-entry key holding register with overrun reporting.
module keypad_scanner #(
  parameter int SCAN_CYCLES     = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rows_sync,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  localparam logic [7:0]  DWELL_LAST = 8'(SCAN_CYCLES - 1);
  localparam logic [15:0] DEB_LAST   = 16'(DEBOUNCE_CYCLES - 1);

  state_t      state, state_nxt;
  logic [7:0]  dwell_cnt, dwell_nxt;
  logic [15:0] deb_cnt, deb_nxt;
  logic [1:0]  col_idx, col_nxt;
  logic [1:0]  row_idx, row_nxt;
  logic [3:0]  code_nxt;
  logic        valid_nxt;
  logic        overrun_nxt;
  logic        deliver;
  logic        row_one_hot;
  logic [1:0]  row_enc;
  logic [3:0]  row_captured;

  // Exactly one row active; zero or several rows (ghosting) are rejected.
  assign row_one_hot  = (rows_sync != 4'd0) && ((rows_sync & (rows_sync - 4'd1)) == 4'd0);
  assign row_captured = 4'b0001 << row_idx;

  always_comb begin
    row_enc = 2'd0;
    case (rows_sync)
      4'b0010: row_enc = 2'd1;
      4'b0100: row_enc = 2'd2;
      4'b1000: row_enc = 2'd3;
      default: row_enc = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SCAN;
      dwell_cnt <= 8'd0;
      deb_cnt   <= 16'd0;
      col_idx   <= 2'd0;
      row_idx   <= 2'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      dwell_cnt <= dwell_nxt;
      deb_cnt   <= deb_nxt;
      col_idx   <= col_nxt;
      row_idx   <= row_nxt;
      key_code  <= code_nxt;
      key_valid <= valid_nxt;
      overrun   <= overrun_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    dwell_nxt   = dwell_cnt;
    deb_nxt     = deb_cnt;
    col_nxt     = col_idx;
    row_nxt     = row_idx;
    code_nxt    = key_code;
    valid_nxt   = key_valid;
    overrun_nxt = 1'b0;
    deliver     = 1'b0;

    case (state)
      SCAN: begin
        // Rows are only trusted at the end of the dwell, after synchronizer latency.
        if (dwell_cnt == DWELL_LAST) begin
          dwell_nxt = 8'd0;
          if (row_one_hot) begin
            row_nxt   = row_enc;
            deb_nxt   = 16'd0;
            state_nxt = DEBOUNCE;
          end else begin
            col_nxt = col_idx + 2'd1;
          end
        end else begin
          dwell_nxt = dwell_cnt + 8'd1;
        end
      end

      DEBOUNCE: begin
        if (rows_sync == row_captured) begin
          if (deb_cnt == DEB_LAST) begin
            deb_nxt   = 16'd0;
            state_nxt = PRESSED;
          end else begin
            deb_nxt = deb_cnt + 16'd1;
          end
        end else begin
          deb_nxt   = 16'd0;
          dwell_nxt = 8'd0;
          col_nxt   = col_idx + 2'd1;
          state_nxt = SCAN;
        end
      end

      PRESSED: begin
        deliver   = 1'b1;
        deb_nxt   = 16'd0;
        state_nxt = RELEASE_WAIT;
      end

      RELEASE_WAIT: begin
        if (rows_sync == 4'd0) begin
          if (deb_cnt == DEB_LAST) begin
            deb_nxt   = 16'd0;
            dwell_nxt = 8'd0;
            col_nxt   = col_idx + 2'd1;
            state_nxt = SCAN;
          end else begin
            deb_nxt = deb_cnt + 16'd1;
          end
        end else begin
          deb_nxt = 16'd0;
        end
      end

      default: begin
        state_nxt = SCAN;
        dwell_nxt = 8'd0;
        deb_nxt   = 16'd0;
      end
    endcase

    // An ack in the delivery cycle frees the holding register for the new key.
    if (deliver) begin
      if (!key_valid || key_ack) begin
        code_nxt  = {row_idx, col_idx};
        valid_nxt = 1'b1;
      end else begin
        overrun_nxt = 1'b1;
      end
    end else if (key_valid && key_ack) begin
      valid_nxt = 1'b0;
    end
  end

  assign cols = 4'b0001 << col_idx;
  assign busy = (state != SCAN);

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed bench for keypad_scanner with a keypad model,
// a 4-stage row synchronizer and a scoreboard of expected deliveries.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] rows_sync;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       overrun;
  logic       busy;

  logic [15:0] pressed;
  logic [3:0]  rows_raw;
  logic [3:0]  sync0 = '0, sync1 = '0, sync2 = '0, sync3 = '0;
  logic        valid_q = 1'b0;
  logic        ack_q = 1'b0;

  int checks = 0;
  int errors = 0;
  int ovr_cnt = 0;
  int dlv_cnt = 0;
  logic [3:0] exp_q[$];

  keypad_scanner #(.SCAN_CYCLES(8), .DEBOUNCE_CYCLES(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .rows_sync (rows_sync),
    .cols      (cols),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ack   (key_ack),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // A pressed key connects its row to its column while that column is driven.
  always_comb begin
    rows_raw = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && cols[c]) rows_raw[r] = 1'b1;
  end

  always_ff @(posedge clk) begin
    sync0   <= rows_raw;
    sync1   <= sync0;
    sync2   <= sync1;
    sync3   <= sync2;
    valid_q <= key_valid;
    ack_q   <= key_ack;
  end
  assign rows_sync = sync3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and score any new delivery seen there.
  task automatic step();
    logic [3:0] e;
    @(negedge clk);
    if (overrun) ovr_cnt++;
    if (key_valid && (!valid_q || ack_q)) begin
      dlv_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_delivery", 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        chk("delivery_code", 32'(key_code), 32'(e));
      end
    end
  endtask

  task automatic wait_busy(input logic lvl, input int n, input string tag);
    int i = 0;
    while (busy !== lvl && i < n) begin step(); i++; end
    chk(tag, 32'(busy), 32'(lvl));
  endtask

  task automatic wait_valid(input int n, input string tag);
    int i = 0;
    while (key_valid !== 1'b1 && i < n) begin step(); i++; end
    chk(tag, 32'(key_valid), 32'(1));
  endtask

  task automatic ack_pulse();
    key_ack = 1'b1;
    step();
    key_ack = 1'b0;
    chk("ack_clears_valid", 32'(key_valid), 32'(0));
  endtask

  initial begin
    int i;
    int ovr0;
    int busy_hi;
    int valid_hi;
    int col_changes;
    logic [3:0] prev_cols;

    rst = 1'b1;
    key_ack = 1'b0;
    pressed = '0;
    step();
    step();
    chk("rst_cols", 32'(cols), 32'(4'b0001));
    chk("rst_key_valid", 32'(key_valid), 32'(0));
    chk("rst_key_code", 32'(key_code), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_overrun", 32'(overrun), 32'(0));

    // Key 9 (row 2, col 1) held from reset release; exact cycle timeline.
    rst = 1'b0;
    pressed[9] = 1'b1;
    exp_q.push_back(4'd9);
    for (int k = 0; k <= 34; k++) begin
      chk($sformatf("t30_cols_c%0d", k), 32'(cols), (k < 8) ? 32'(1) : 32'(2));
      chk($sformatf("t30_busy_c%0d", k), 32'(busy), (k >= 16) ? 32'(1) : 32'(0));
      chk($sformatf("t30_valid_c%0d", k), 32'(key_valid), (k >= 33) ? 32'(1) : 32'(0));
      step();
    end
    chk("t30_key_code", 32'(key_code), 32'(9));
    ack_pulse();
    pressed[9] = 1'b0;
    wait_busy(1'b0, 200, "t30_release_idle");

    // Key 3 (row 0, col 3) with two 3-cycle bounce gaps during debounce.
    pressed[3] = 1'b1;
    for (int g = 0; g < 2; g++) begin
      wait_busy(1'b1, 100, "t31_enter_debounce");
      repeat (5) step();
      pressed[3] = 1'b0;
      repeat (3) step();
      pressed[3] = 1'b1;
      wait_busy(1'b0, 20, "t31_bounce_aborts");
    end
    exp_q.push_back(4'd3);
    wait_valid(300, "t31_valid");
    repeat (120) step();
    chk("t31_single_delivery", 32'(dlv_cnt), 32'(2));
    chk("t31_still_pressed_busy", 32'(busy), 32'(1));
    ack_pulse();
    pressed[3] = 1'b0;
    wait_busy(1'b0, 200, "t31_release_idle");

    // Rows 1 and 3 both active on col 0: ghosting, never debounced.
    pressed[4] = 1'b1;
    pressed[12] = 1'b1;
    busy_hi = 0;
    valid_hi = 0;
    col_changes = 0;
    prev_cols = cols;
    for (int k = 0; k < 80; k++) begin
      step();
      if (busy) busy_hi++;
      if (key_valid) valid_hi++;
      if (cols != prev_cols) col_changes++;
      prev_cols = cols;
    end
    chk("t32_busy_cycles", 32'(busy_hi), 32'(0));
    chk("t32_valid_cycles", 32'(valid_hi), 32'(0));
    chk("t32_col_rotations", 32'(col_changes), 32'(10));
    pressed[4] = 1'b0;
    pressed[12] = 1'b0;
    repeat (10) step();

    // Key 5 pending without ack, key 10 confirmed -> overrun.
    pressed[5] = 1'b1;
    exp_q.push_back(4'd5);
    wait_valid(200, "t33_valid5");
    pressed[5] = 1'b0;
    wait_busy(1'b0, 200, "t33_release5");
    pressed[10] = 1'b1;
    ovr0 = ovr_cnt;
    i = 0;
    while (ovr_cnt == ovr0 && i < 300) begin step(); i++; end
    chk("t33_overrun_seen", 32'(ovr_cnt - ovr0), 32'(1));
    chk("t33_code_kept", 32'(key_code), 32'(5));
    chk("t33_valid_kept", 32'(key_valid), 32'(1));
    step();
    chk("t33_overrun_one_cycle", 32'(overrun), 32'(0));
    ack_pulse();
    pressed[10] = 1'b0;
    wait_busy(1'b0, 200, "t33_release10");

    // Key 4 pending; ack lands in the PRESSED cycle of key 7.
    pressed[4] = 1'b1;
    exp_q.push_back(4'd4);
    wait_valid(200, "t34_valid4");
    pressed[4] = 1'b0;
    wait_busy(1'b0, 200, "t34_release4");
    pressed[7] = 1'b1;
    ovr0 = ovr_cnt;
    wait_busy(1'b1, 200, "t34_enter_debounce");
    repeat (16) step();
    chk("t34_code_before", 32'(key_code), 32'(4));
    exp_q.push_back(4'd7);
    key_ack = 1'b1;
    step();
    key_ack = 1'b0;
    chk("t34_code7", 32'(key_code), 32'(7));
    chk("t34_valid_stays", 32'(key_valid), 32'(1));
    step();
    chk("t34_no_overrun", 32'(ovr_cnt - ovr0), 32'(0));
    ack_pulse();
    pressed[7] = 1'b0;
    wait_busy(1'b0, 200, "t34_release7");

    // Reset during RELEASE_WAIT with a pending key; held key detected again.
    pressed[14] = 1'b1;
    exp_q.push_back(4'd14);
    wait_valid(200, "t35_valid14");
    repeat (5) step();
    chk("t35_in_release_wait", 32'(busy), 32'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t35_cols", 32'(cols), 32'(4'b0001));
    chk("t35_valid", 32'(key_valid), 32'(0));
    chk("t35_code", 32'(key_code), 32'(0));
    chk("t35_busy", 32'(busy), 32'(0));
    exp_q.delete();
    exp_q.push_back(4'd14);
    wait_valid(200, "t35_redetect");
    ack_pulse();
    pressed[14] = 1'b0;
    wait_busy(1'b0, 200, "t35_release14");

    chk("final_queue_empty", 32'(exp_q.size()), 32'(0));
    chk("final_overruns", 32'(ovr_cnt), 32'(1));
    chk("final_deliveries", 32'(dlv_cnt), 32'(7));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_CYCLES, default 8, clocks each column is driven per scan step; legal range 6..255.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16, consecutive stable clocks required for press and for release; legal range 1..65535.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port rows_sync  input  4  keypad row lines after the 4-stage input synchronizer; bit i high = row i active.
REQ-006 SHALL have port cols  output  4  one-hot column drive to the keypad.
REQ-007 SHALL have port key_code  output  4  confirmed key, value = row_idx*4 + col_idx.
REQ-008 SHALL have port key_valid  output  1  key_code holds an unacknowledged key.
REQ-009 SHALL have port key_ack  input  1  consumer accepts key_code.
REQ-010 SHALL have port overrun  output  1  one-cycle pulse when a confirmed key is dropped.
REQ-011 SHALL have port busy  output  1  high in every state except SCAN.

Function
REQ-012 SHALL implement states SCAN, DEBOUNCE, PRESSED, RELEASE_WAIT.
REQ-013 SCAN: SHALL drive cols one-hot for SCAN_CYCLES clocks, then rotate 0001->0010->0100->1000->0001.
REQ-014 SCAN: SHALL sample rows_sync only in the last clock of each column dwell (covers 4-cycle synchronizer latency plus settling).
REQ-015 SCAN: sample with exactly one row bit set SHALL capture row index and column index and enter DEBOUNCE with cols held.
REQ-016 SCAN: sample with zero or more than one row bit set SHALL be ignored (multi-key ghosting); scanning continues.
REQ-017 DEBOUNCE: SHALL count clocks while rows_sync equals the captured one-hot row; any mismatch SHALL return to SCAN at the next column with counter cleared.
REQ-018 DEBOUNCE: after DEBOUNCE_CYCLES consecutive matching clocks SHALL enter PRESSED.
REQ-019 PRESSED: single-cycle state; SHALL perform the delivery of REQ-021..REQ-023, then enter RELEASE_WAIT.
REQ-020 RELEASE_WAIT: cols held; SHALL return to SCAN (next column, fresh dwell) after DEBOUNCE_CYCLES consecutive clocks of rows_sync==0; any nonzero clock restarts the count.
REQ-021 Delivery with key_valid low, or with key_valid high and key_ack high in the same cycle: SHALL load key_code and hold key_valid high from the next clock.
REQ-022 Delivery with key_valid high and key_ack low: SHALL keep key_code unchanged and pulse overrun for one clock.
REQ-023 key_ack with key_valid high and no delivery SHALL clear key_valid next clock; key_ack with key_valid low SHALL be ignored.
REQ-024 key_code SHALL be stable whenever key_valid is high.
REQ-025 Each physical press SHALL produce at most one delivery regardless of hold time.
REQ-026 Counters SHALL be sized for the parameter maxima and SHALL not wrap.

Reset
REQ-027 rst high at a clock edge SHALL set state SCAN, cols=4'b0001, dwell and debounce counters 0, key_code=0, key_valid=0, overrun=0, busy=0.
REQ-028 rst asserted in any state, including mid-debounce or with key_valid high, SHALL abort the operation, discard any pending key, and apply REQ-027 values.
REQ-029 First column dwell after reset release SHALL be a full SCAN_CYCLES.

Verification
REQ-030 Defaults, key row 2 col 1 held from reset release -> cols 0001 cycles 0-7, 0010 from cycle 8, sample at cycle 15, key_valid rises cycle 33 with key_code=9, busy high from cycle 16.
REQ-031 Press row 0 col 3 with 3-cycle bounce gaps during DEBOUNCE, then stable -> counter restarts on each gap; exactly one delivery key_code=3 after final 16 stable clocks.
REQ-032 Rows 1 and 3 both active on col 0 -> no DEBOUNCE entry, cols keep rotating, key_valid stays 0.
REQ-033 Key 5 delivered, no ack, key 10 pressed and confirmed -> overrun pulses 1 clock, key_code stays 5; ack then -> key_valid 0 next clock.
REQ-034 key_ack asserted in the same cycle as PRESSED for key 7 while key 4 pending -> key_code=7, key_valid stays 1, no overrun.
REQ-035 rst pulsed for 1 clock during RELEASE_WAIT with key_valid=1 -> next clock cols=0001, key_valid=0, key_code=0, busy=0; held key re-detected as new press.
